// File: rtl/yukle_kaydet_birimi_pkg.sv
// yks_paket: shared definitions for the load/store unit.
//   - funct3 access-type codes (TUR_*)
//   - FSM state encoding (BOSTA, OKU, YAZ, YANIT)
//   - tur_yasal(): access-type / alignment legality check
// Configuration macro: YKB_HIZALAMA_HATA_EN -- when defined, misaligned H/HU/W
// accesses are treated as illegal instead of being aligned down.
package yks_paket;

    localparam logic [2:0] TUR_B  = 3'b000;
    localparam logic [2:0] TUR_H  = 3'b001;
    localparam logic [2:0] TUR_W  = 3'b010;
    localparam logic [2:0] TUR_BU = 3'b100;
    localparam logic [2:0] TUR_HU = 3'b101;

`ifdef YKB_HIZALAMA_HATA_EN
    localparam bit HIZALAMA_HATA = 1'b1;
`else
    localparam bit HIZALAMA_HATA = 1'b0;
`endif

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        OKU   = 2'd1,
        YAZ   = 2'd2,
        YANIT = 2'd3
    } durum_t;

    // Range checking lives in the top, which owns the memory-size parameter.
    function automatic logic tur_yasal(input logic yaz, input logic [2:0] tur,
                                       input logic [1:0] alt);
        logic tur_ok;
        logic hizasiz;
        if (yaz) begin
            tur_ok = (tur == TUR_B) || (tur == TUR_H) || (tur == TUR_W);
        end else begin
            tur_ok = (tur == TUR_B) || (tur == TUR_H) || (tur == TUR_W) ||
                     (tur == TUR_BU) || (tur == TUR_HU);
        end
        hizasiz = (((tur == TUR_H) || (tur == TUR_HU)) && alt[0]) ||
                  ((tur == TUR_W) && (alt != 2'b00));
        return tur_ok && !(HIZALAMA_HATA && hizasiz);
    endfunction

endpackage

// File: rtl/yukle_kaydet_birimi_bayt_hizala.sv
// bayt_hizala: combinational lane steering for the load/store unit.
//   kelime_i   : 32-bit memory word (fresh read data or the captured word)
//   tur_i      : funct3 access type
//   adres_i    : byte offset within the word
//   veri_i     : store data (low bits used for B/H)
//   yukle_o    : extracted, sign/zero-extended load value
//   birlesik_o : kelime_i with the addressed lanes replaced by store data
// Offsets below the access size are ignored (aligned down).
module bayt_hizala (
    input  logic [31:0] kelime_i,
    input  logic [2:0]  tur_i,
    input  logic [1:0]  adres_i,
    input  logic [31:0] veri_i,
    output logic [31:0] yukle_o,
    output logic [31:0] birlesik_o
);
    import yks_paket::*;

    logic [7:0]  bayt;
    logic [15:0] yarim;

    always_comb begin
        bayt = 8'h00;
        unique case (adres_i)
            2'd0: bayt = kelime_i[7:0];
            2'd1: bayt = kelime_i[15:8];
            2'd2: bayt = kelime_i[23:16];
            2'd3: bayt = kelime_i[31:24];
            default: bayt = 8'h00;
        endcase
        yarim = adres_i[1] ? kelime_i[31:16] : kelime_i[15:0];

        // tur_i may hold an illegal code after an error response, hence plain case.
        case (tur_i)
            TUR_B:   yukle_o = {{24{bayt[7]}}, bayt};
            TUR_BU:  yukle_o = {24'h000000, bayt};
            TUR_H:   yukle_o = {{16{yarim[15]}}, yarim};
            TUR_HU:  yukle_o = {16'h0000, yarim};
            default: yukle_o = kelime_i;
        endcase

        birlesik_o = kelime_i;
        case (tur_i)
            TUR_B: begin
                unique case (adres_i)
                    2'd0: birlesik_o[7:0]   = veri_i[7:0];
                    2'd1: birlesik_o[15:8]  = veri_i[7:0];
                    2'd2: birlesik_o[23:16] = veri_i[7:0];
                    2'd3: birlesik_o[31:24] = veri_i[7:0];
                    default: birlesik_o = kelime_i;
                endcase
            end
            TUR_H: begin
                if (adres_i[1]) birlesik_o[31:16] = veri_i[15:0];
                else            birlesik_o[15:0]  = veri_i[15:0];
            end
            default: birlesik_o = veri_i;
        endcase
    end

endmodule

// File: rtl/yukle_kaydet_birimi.sv
// yukle_kaydet_birimi: load/store unit in front of a word-addressed data memory.
// Requests arrive on a valid/ready handshake; every legal access reads the
// word first (OKU), stores then write the merged word back (YAZ), and a
// single-cycle response pulse follows (YANIT). Illegal requests skip straight
// to YANIT with the fault flag set and never touch memory.
// Ports:
//   clk_i, rst_i                 : clock, asynchronous active-high reset
//   istek_*                      : request handshake, type, address, store data
//   yanit_gecerli_o/veri_o/hata_o: response pulse, load data, fault
//   bellek_adres_o/wen_o/veri_o  : word address, write enable, write data
//   bellek_veri_i                : asynchronous memory read data
// Configuration macro: YKB_HIZALAMA_HATA_EN (misaligned H/HU/W become faults).
module yukle_kaydet_birimi #(
    parameter int unsigned BELLEK_BAYT = 2048,
    parameter int unsigned ADRES_BIT   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 istek_gecerli_i,
    output logic                 istek_hazir_o,
    input  logic                 istek_yaz_i,
    input  logic [2:0]           istek_tur_i,
    input  logic [ADRES_BIT-1:0] istek_adres_i,
    input  logic [31:0]          istek_veri_i,
    output logic                 yanit_gecerli_o,
    output logic [31:0]          yanit_veri_o,
    output logic                 yanit_hata_o,
    output logic [ADRES_BIT-1:0] bellek_adres_o,
    output logic                 bellek_wen_o,
    output logic [31:0]          bellek_veri_o,
    input  logic [31:0]          bellek_veri_i
);
    import yks_paket::*;

    durum_t                 durum_q, durum_d;
    logic                   yaz_q;
    logic [2:0]             tur_q;
    logic [ADRES_BIT-1:0]   adres_q;
    logic [31:0]            veri_q;
    logic [31:0]            okunan_q;
    logic [31:0]            yanit_veri_q;
    logic                   hata_q;

    logic                   el_sikisma;
    logic                   yasal;
    logic [31:0]            hiza_kelime;
    logic [31:0]            yukle;
    logic [31:0]            birlesik;
    logic [ADRES_BIT-1:0]   kelime_adres;

    assign el_sikisma   = (durum_q == BOSTA) && istek_gecerli_i;
    assign yasal        = (istek_adres_i < ADRES_BIT'(BELLEK_BAYT)) &&
                          tur_yasal(istek_yaz_i, istek_tur_i, istek_adres_i[1:0]);
    assign kelime_adres = {adres_q[ADRES_BIT-1:2], 2'b00};
    // Loads extract straight from the bus in OKU; merges use the captured word.
    assign hiza_kelime  = (durum_q == OKU) ? bellek_veri_i : okunan_q;
    assign yanit_veri_o = yanit_veri_q;

    bayt_hizala u_bayt_hizala (
        .kelime_i   (hiza_kelime),
        .tur_i      (tur_q),
        .adres_i    (adres_q[1:0]),
        .veri_i     (veri_q),
        .yukle_o    (yukle),
        .birlesik_o (birlesik)
    );

    always_comb begin
        durum_d         = durum_q;
        istek_hazir_o   = 1'b0;
        yanit_gecerli_o = 1'b0;
        yanit_hata_o    = 1'b0;
        bellek_adres_o  = '0;
        bellek_wen_o    = 1'b0;
        bellek_veri_o   = '0;
        unique case (durum_q)
            BOSTA: begin
                istek_hazir_o = 1'b1;
                if (istek_gecerli_i) durum_d = yasal ? OKU : YANIT;
            end
            OKU: begin
                bellek_adres_o = kelime_adres;
                durum_d        = yaz_q ? YAZ : YANIT;
            end
            YAZ: begin
                bellek_adres_o = kelime_adres;
                bellek_wen_o   = 1'b1;
                bellek_veri_o  = birlesik;
                durum_d        = YANIT;
            end
            YANIT: begin
                yanit_gecerli_o = 1'b1;
                yanit_hata_o    = hata_q;
                durum_d         = BOSTA;
            end
            default: durum_d = BOSTA;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q      <= BOSTA;
            yaz_q        <= 1'b0;
            tur_q        <= 3'b000;
            adres_q      <= '0;
            veri_q       <= '0;
            okunan_q     <= '0;
            yanit_veri_q <= '0;
            hata_q       <= 1'b0;
        end else begin
            durum_q <= durum_d;
            if (el_sikisma) begin
                yaz_q   <= istek_yaz_i;
                tur_q   <= istek_tur_i;
                adres_q <= istek_adres_i;
                veri_q  <= istek_veri_i;
                hata_q  <= !yasal;
                if (!yasal) yanit_veri_q <= '0;
            end
            if (durum_q == OKU) begin
                okunan_q <= bellek_veri_i;
                if (!yaz_q) yanit_veri_q <= yukle;
            end
            // Store responses carry zero; updated only as YANIT is entered.
            if (durum_q == YAZ) yanit_veri_q <= '0;
        end
    end

endmodule

// File: tb/tb_yukle_kaydet_birimi.sv
// Self-checking bench for yukle_kaydet_birimi: a directed vector table, a
// reset-during-access sequence, then randomized requests against a byte-array
// reference model. A simple word memory is attached to the DUT memory port.
module tb_yukle_kaydet_birimi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        istek_gecerli = 1'b0;
    logic        istek_hazir;
    logic        istek_yaz = 1'b0;
    logic [2:0]  istek_tur = 3'b000;
    logic [31:0] istek_adres = '0;
    logic [31:0] istek_veri = '0;
    logic        yanit_gecerli;
    logic [31:0] yanit_veri;
    logic        yanit_hata;
    logic [31:0] bellek_adres;
    logic        bellek_wen;
    logic [31:0] bellek_veri_yaz;
    logic [31:0] bellek_veri_oku;

    always #5 clk = ~clk;

    yukle_kaydet_birimi #(
        .BELLEK_BAYT (2048),
        .ADRES_BIT   (32)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .istek_gecerli_i (istek_gecerli),
        .istek_hazir_o   (istek_hazir),
        .istek_yaz_i     (istek_yaz),
        .istek_tur_i     (istek_tur),
        .istek_adres_i   (istek_adres),
        .istek_veri_i    (istek_veri),
        .yanit_gecerli_o (yanit_gecerli),
        .yanit_veri_o    (yanit_veri),
        .yanit_hata_o    (yanit_hata),
        .bellek_adres_o  (bellek_adres),
        .bellek_wen_o    (bellek_wen),
        .bellek_veri_o   (bellek_veri_yaz),
        .bellek_veri_i   (bellek_veri_oku)
    );

    // Memory attached to the DUT
    logic [31:0] mem [512];
    logic        mem_temizle = 1'b1;
    always @(posedge clk) begin
        if (mem_temizle) begin
            for (int i = 0; i < 512; i++) mem[i] <= '0;
        end else if (bellek_wen) begin
            mem[bellek_adres[10:2]] <= bellek_veri_yaz;
        end
    end
    assign bellek_veri_oku = mem[bellek_adres[10:2]];

    // Reference model: little-endian byte array
    logic [7:0] ref_b [2048];
    int toplam = 0;
    int hatali = 0;

    typedef struct {
        logic        yaz;
        logic [2:0]  tur;
        logic [31:0] adres;
        logic [31:0] veri;
        logic [31:0] bek_veri;
        logic        bek_hata;
        logic [31:0] bek_yazilan;
    } vektor_t;
    vektor_t tablo[$];

    function automatic int boyut(input logic [2:0] tur);
        if (tur == 3'd0 || tur == 3'd4) return 1;
        if (tur == 3'd1 || tur == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit ref_yasal(input bit yaz, input logic [2:0] tur, input logic [31:0] a);
        bit ok;
        if (a >= 32'd2048) return 1'b0;
        if (yaz) ok = (tur == 3'd0) || (tur == 3'd1) || (tur == 3'd2);
        else     ok = (tur == 3'd0) || (tur == 3'd1) || (tur == 3'd2) ||
                      (tur == 3'd4) || (tur == 3'd5);
`ifdef YKB_HIZALAMA_HATA_EN
        if (a % boyut(tur) != 0) ok = 1'b0;
`endif
        return ok;
    endfunction

    function automatic logic [31:0] ref_kelime(input logic [31:0] a);
        longint v = 0;
        int unsigned t = a - (a % 4);
        for (int i = 3; i >= 0; i--) v = v * 256 + longint'(ref_b[t + i]);
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_oku(input logic [2:0] tur, input logic [31:0] a);
        int n = boyut(tur);
        int unsigned t = a - (a % n);
        longint v = 0;
        for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(ref_b[t + i]);
        if (tur == 3'd0 && v >= 128)   v = v - 256;
        if (tur == 3'd1 && v >= 32768) v = v - 65536;
        return v[31:0];
    endfunction

    task automatic ref_yaz(input logic [2:0] tur, input logic [31:0] a, input logic [31:0] d);
        int n = boyut(tur);
        int unsigned t = a - (a % n);
        for (int i = 0; i < n; i++) ref_b[t + i] = 8'((d >> (8 * i)) & 32'hFF);
    endtask

    task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        toplam++;
        if (gercek !== beklenen) begin
            hatali++;
            $display("FAIL %s: actual=%h required=%h", ad, gercek, beklenen);
        end
    endtask

    task automatic istek_yap(input logic yaz, input logic [2:0] tur, input logic [31:0] adres,
                             input logic [31:0] veri, output int gecikme,
                             output logic [31:0] rveri, output logic rhata, output int wen_sayi,
                             output int wen_cyc, output logic [31:0] wen_veri,
                             output logic [31:0] wen_adres);
        gecikme = -1; rveri = '0; rhata = 1'b0;
        wen_sayi = 0; wen_cyc = -1; wen_veri = '0; wen_adres = '0;
        @(negedge clk);
        kontrol("hazir_once", {31'b0, istek_hazir}, 32'h1);
        istek_yaz = yaz; istek_tur = tur; istek_adres = adres; istek_veri = veri;
        istek_gecerli = 1'b1;
        @(posedge clk);
        #1;
        istek_gecerli = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (bellek_wen) begin
                wen_sayi++; wen_cyc = k; wen_veri = bellek_veri_yaz; wen_adres = bellek_adres;
            end
            if (yanit_gecerli) begin
                gecikme = k; rveri = yanit_veri; rhata = yanit_hata;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (gecikme != -1) begin
            @(posedge clk);
            #1;
            kontrol("darbe_sonrasi", {30'b0, yanit_gecerli, istek_hazir}, 32'h1);
        end
    endtask

    task automatic uygula(input string ad, input logic yaz, input logic [2:0] tur,
                          input logic [31:0] adres, input logic [31:0] veri,
                          input logic [31:0] bek_veri, input logic bek_hata,
                          input logic [31:0] bek_yazilan);
        int gecikme, wen_sayi, wen_cyc;
        logic [31:0] rveri, wen_veri, wen_adres;
        logic rhata;
        int bek_gec;
        istek_yap(yaz, tur, adres, veri, gecikme, rveri, rhata, wen_sayi, wen_cyc, wen_veri,
                  wen_adres);
        bek_gec = bek_hata ? 1 : (yaz ? 3 : 2);
        kontrol({ad, ".gecikme"}, gecikme, bek_gec);
        kontrol({ad, ".veri"}, rveri, bek_veri);
        kontrol({ad, ".hata"}, {31'b0, rhata}, {31'b0, bek_hata});
        kontrol({ad, ".wen_sayisi"}, wen_sayi, (yaz && !bek_hata) ? 1 : 0);
        if (yaz && !bek_hata) begin
            kontrol({ad, ".wen_cevrim"}, wen_cyc, 2);
            kontrol({ad, ".wen_veri"}, wen_veri, bek_yazilan);
            kontrol({ad, ".wen_adres"}, wen_adres, adres & ~32'h3);
        end
    endtask

    initial begin
        logic [31:0] lh_veri;
        logic        lh_hata;
        logic [31:0] kel_once;

        for (int i = 0; i < 2048; i++) ref_b[i] = 8'h00;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        kontrol("rst.yanit_gecerli", {31'b0, yanit_gecerli}, 32'h0);
        kontrol("rst.yanit_hata", {31'b0, yanit_hata}, 32'h0);
        kontrol("rst.wen", {31'b0, bellek_wen}, 32'h0);
        kontrol("rst.yanit_veri", yanit_veri, 32'h0);
        kontrol("rst.bellek_adres", bellek_adres, 32'h0);
        kontrol("rst.bellek_veri", bellek_veri_yaz, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mem_temizle = 1'b0;
        #1;
        kontrol("rst.hazir", {31'b0, istek_hazir}, 32'h1);

`ifdef YKB_HIZALAMA_HATA_EN
        lh_veri = 32'h0;        lh_hata = 1'b1;
`else
        lh_veri = 32'hFFFFAABB; lh_hata = 1'b0;
`endif
        //                 yaz   tur     adres          veri           bek_veri       hata  yazilan
        tablo.push_back('{1'b1, 3'b010, 32'h00000010, 32'h8899AABB, 32'h00000000, 1'b0, 32'h8899AABB});
        tablo.push_back('{1'b0, 3'b000, 32'h00000011, 32'h0,        32'hFFFFFFAA, 1'b0, 32'h0});
        tablo.push_back('{1'b0, 3'b101, 32'h00000012, 32'h0,        32'h00008899, 1'b0, 32'h0});
        tablo.push_back('{1'b0, 3'b010, 32'h00000010, 32'h0,        32'h8899AABB, 1'b0, 32'h0});
        tablo.push_back('{1'b0, 3'b100, 32'h00000010, 32'h0,        32'h000000BB, 1'b0, 32'h0});
        tablo.push_back('{1'b0, 3'b001, 32'h00000012, 32'h0,        32'hFFFF8899, 1'b0, 32'h0});
        tablo.push_back('{1'b1, 3'b000, 32'h00000013, 32'hFFFFFF55, 32'h00000000, 1'b0, 32'h5599AABB});
        tablo.push_back('{1'b0, 3'b010, 32'h00000010, 32'h0,        32'h5599AABB, 1'b0, 32'h0});
        tablo.push_back('{1'b1, 3'b010, 32'h00000800, 32'hDEADBEEF, 32'h00000000, 1'b1, 32'h0});
        tablo.push_back('{1'b0, 3'b001, 32'h00000011, 32'h0,        lh_veri,      lh_hata, 32'h0});
        tablo.push_back('{1'b0, 3'b011, 32'h00000010, 32'h0,        32'h00000000, 1'b1, 32'h0});
        tablo.push_back('{1'b1, 3'b100, 32'h00000010, 32'h0,        32'h00000000, 1'b1, 32'h0});
        tablo.push_back('{1'b1, 3'b001, 32'h000007FE, 32'hABCD1234, 32'h00000000, 1'b0, 32'h12340000});
        tablo.push_back('{1'b0, 3'b010, 32'h000007FC, 32'h0,        32'h12340000, 1'b0, 32'h0});
        tablo.push_back('{1'b0, 3'b000, 32'h000007FF, 32'h0,        32'h00000012, 1'b0, 32'h0});
        tablo.push_back('{1'b0, 3'b010, 32'hFFFFFFFC, 32'h0,        32'h00000000, 1'b1, 32'h0});

        foreach (tablo[i]) begin
            uygula($sformatf("tablo%0d", i), tablo[i].yaz, tablo[i].tur, tablo[i].adres,
                   tablo[i].veri, tablo[i].bek_veri, tablo[i].bek_hata, tablo[i].bek_yazilan);
            if (tablo[i].yaz && !tablo[i].bek_hata)
                ref_yaz(tablo[i].tur, tablo[i].adres, tablo[i].veri);
        end

        // Reset during OKU of a store: no write, unit idle afterwards
        kel_once = ref_kelime(32'h10);
        @(negedge clk);
        istek_yaz = 1'b1; istek_tur = 3'b001; istek_adres = 32'h12; istek_veri = 32'h0000BEEF;
        istek_gecerli = 1'b1;
        @(posedge clk);
        #1;
        istek_gecerli = 1'b0;
        rst = 1'b1;
        #1;
        kontrol("rst_orta.wen", {31'b0, bellek_wen}, 32'h0);
        kontrol("rst_orta.yanit_gecerli", {31'b0, yanit_gecerli}, 32'h0);
        kontrol("rst_orta.bellek_adres", bellek_adres, 32'h0);
        @(posedge clk);
        #1;
        kontrol("rst_orta.wen2", {31'b0, bellek_wen}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        kontrol("rst_orta.hazir", {31'b0, istek_hazir}, 32'h1);
        repeat (3) begin
            @(posedge clk);
            #1;
            kontrol("rst_orta.sessiz", {30'b0, bellek_wen, yanit_gecerli}, 32'h0);
        end
        kontrol("rst_orta.bellek", mem[4], kel_once);

        // Randomized requests against the reference model
        for (int n = 0; n < 300; n++) begin
            logic        yaz;
            logic [2:0]  tur;
            logic [31:0] adres, veri, bek_veri, bek_yazilan;
            bit          yasal;
            logic [2:0]  turler [5];
            turler = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            yaz = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) tur = 3'($urandom_range(0, 7));
            else                           tur = turler[$urandom_range(0, 4)];
            if ($urandom_range(0, 15) == 0) adres = $urandom() | 32'h800;
            else                            adres = 32'($urandom_range(0, 2047));
            veri = $urandom();
            yasal = ref_yasal(yaz, tur, adres);
            bek_veri = '0;
            bek_yazilan = '0;
            if (yasal && yaz) begin
                ref_yaz(tur, adres, veri);
                bek_yazilan = ref_kelime(adres);
            end else if (yasal) begin
                bek_veri = ref_oku(tur, adres);
            end
            uygula($sformatf("rast%0d", n), yaz, tur, adres, veri, bek_veri, !yasal, bek_yazilan);
        end

        // Memory contents against the model
        for (int w = 0; w < 512; w++)
            kontrol($sformatf("bellek[%0d]", w), mem[w], ref_kelime(32'(w * 4)));

        $display("test done: total=%0d bad=%0d", toplam, hatali);
        $finish;
    end

endmodule

// File: doc/yukle_kaydet_birimi.md
Name: yukle_kaydet_birimi

Overview:
- Load/store unit sitting directly upstream of the 2 KiB word-addressed data memory (`bellek`).
- Accepts byte, halfword and word load/store requests from the core over a valid/ready handshake.
- Sub-word stores become read-modify-write sequences, because the memory writes whole 32-bit words only.
- Load data is extracted and sign- or zero-extended, and returned as a one-cycle response pulse.

Parameters:
- BELLEK_BAYT, 2048: memory size in bytes; an address with `istek_adres_i >= BELLEK_BAYT` is out of range.
- ADRES_BIT, 32: request and memory address width.

Ports:
- clk_i  input  1  clock; rising edge.
- rst_i  input  1  reset; asynchronous, active-high.
- istek_gecerli_i  input  1  request valid.
- istek_hazir_o  output  1  unit ready to accept a request.
- istek_yaz_i  input  1  1 = store, 0 = load.
- istek_tur_i  input  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- istek_adres_i  input  32  byte address.
- istek_veri_i  input  32  store data; low bits are used for B/H.
- yanit_gecerli_o  output  1  one-cycle response pulse.
- yanit_veri_o  output  32  extended load data; 0 for stores and errors.
- yanit_hata_o  output  1  access fault; valid while `yanit_gecerli_o` = 1.
- bellek_adres_o  output  32  memory address; bits [1:0] always 00.
- bellek_wen_o  output  1  memory write enable.
- bellek_veri_o  output  32  merged word to write.
- bellek_veri_i  input  32  asynchronous read data from memory.

Behaviour:
- Reset (asynchronous):
  - state goes to BOSTA;
  - `yanit_gecerli_o`, `yanit_hata_o` and `bellek_wen_o` are 0;
  - `yanit_veri_o`, `bellek_adres_o` and `bellek_veri_o` are 0;
  - `istek_hazir_o` is 1 once out of reset.
- Reset mid-operation: the request is dropped and no write is issued. A write already clocked in stays in memory.
- `istek_hazir_o` = 1 only in state BOSTA. A handshake (`istek_gecerli_i` & `istek_hazir_o`) on a rising edge registers yaz, tur, adres and veri.
- States:
  - BOSTA: idle.
    - Handshake on a legal request goes to OKU.
    - Handshake on an illegal request goes to YANIT with hata=1.
  - OKU: drive the registered word address. Capture `bellek_veri_i` into the okunan register.
    - Load goes to YANIT.
    - Store goes to YAZ.
  - YAZ: `bellek_wen_o` = 1 for exactly one cycle; `bellek_veri_o` = okunan with the target lanes replaced. Next state is YANIT.
  - YANIT: `yanit_gecerli_o` = 1 for one cycle. Next state is BOSTA, so `istek_hazir_o` is high again the following cycle.
- Latency (handshake at edge T):
  - load response in cycle T+2;
  - store write at edge T+2, response in cycle T+3;
  - error response in cycle T+1.
- SW also takes the read-modify-write path, so every store has the same latency.
- No back-to-back acceptance: throughput is one request per 3 cycles for loads and 4 for stores.
- Illegal requests raise `yanit_hata_o`; memory is never written for them:
  - load funct3 011, 110 or 111;
  - store funct3 other than 000, 001 or 010;
  - address out of range.
- Load extraction:
  - byte lane selected by adres[1:0];
  - halfword selected by adres[1];
  - B and H are sign-extended; BU and HU are zero-extended.
- Store merge:
  - SB replaces byte lane adres[1:0] with veri[7:0];
  - SH replaces halfword adres[1] with veri[15:0];
  - SW replaces the whole word.
- Misalignment (feature off): address bits below the access size are ignored (aligned down).
- `yanit_veri_o` holds its value outside YANIT. A response carries no ready signal; the core must consume the pulse.

Optional Feature:
- Macro: YKB_HIZALAMA_HATA_EN.
- Defined: a misaligned H/HU access (adres[0]=1) or W access (adres[1:0]≠00) is illegal. It follows the error path: response at T+1, hata=1, no memory access.
- Undefined: such accesses are silently aligned down and `yanit_hata_o` never fires for misalignment.

Decomposition:
- Package `yks_paket` holds:
  - funct3 localparams (TUR_B, TUR_H, TUR_W, TUR_BU, TUR_HU);
  - the state encoding (BOSTA, OKU, YAZ, YANIT);
  - the legality-check function.
- Sub-module `bayt_hizala` is purely combinational. Inputs are okunan word, tur, adres[1:0] and store data; outputs are the extended load value and the merged store word.

Test Plan:
- Memory word at 0x10 = 0x8899AABB; LB @0x11 → response at T+2, `yanit_veri_o` = 0xFFFFFFAA, hata=0.
- Same word; LHU @0x12 → 0x00008899. LW @0x10 → 0x8899AABB.
- SB 0x55 @0x13 on 0x8899AABB → `bellek_wen_o` pulses in cycle T+2 with `bellek_veri_o` = 0x5599AABB; a following LW @0x10 returns 0x5599AABB.
- SW @0x800 (out of range) → response at T+1 with hata=1; `bellek_wen_o` never asserted.
- LH @0x11:
  - with YKB_HIZALAMA_HATA_EN defined → hata=1 at T+1;
  - without it → returns the sign-extended halfword @0x10, hata=0.
- SH issued, then `rst_i` pulsed during OKU → `bellek_wen_o` stays 0, memory unchanged, `istek_hazir_o` = 1 after reset.
